// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: Tuse sentinel,
// forwarding select encodings and MDU operation codes.
package hazard_pkg;

  localparam logic [2:0] TUSE_NONE = 3'd7;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  localparam logic [1:0] MD_NONE  = 2'd0;
  localparam logic [1:0] MD_MULT  = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;

  // Tnew one stage further down the pipe, saturating at zero.
  function automatic logic [2:0] tnew_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage decode inputs and hazard/forward outputs of hazard_ctrl.
// MDU signals exist only when HAZARD_MDU_EN is defined.
interface hazard_ctrl_if;
  logic [4:0] D_A1;
  logic [4:0] D_A2;
  logic [2:0] D_rsTuse;
  logic [2:0] D_rtTuse;
  logic [4:0] D_A3;
  logic [2:0] D_Tnew;
  logic       stall;
  logic [1:0] D_rs_fwd;
  logic [1:0] D_rt_fwd;
  logic [1:0] E_rs_fwd;
  logic [1:0] E_rt_fwd;
  logic [1:0] M_rt_fwd;
`ifdef HAZARD_MDU_EN
  logic [1:0] D_md_start;
  logic       D_md_use;
`endif

  modport master (
    output D_A1, D_A2, D_rsTuse, D_rtTuse, D_A3, D_Tnew,
`ifdef HAZARD_MDU_EN
    output D_md_start, D_md_use,
`endif
    input  stall, D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd
  );

  modport slave (
    input  D_A1, D_A2, D_rsTuse, D_rtTuse, D_A3, D_Tnew,
`ifdef HAZARD_MDU_EN
    input  D_md_start, D_md_use,
`endif
    output stall, D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forwarding selector: youngest ready producer whose destination
// matches the operand address wins; register 0 never matches.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] addr,
  input  logic [4:0] e_a3,
  input  logic       e_rdy,
  input  logic [4:0] m_a3,
  input  logic       m_rdy,
  input  logic [4:0] w_a3,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_NONE;
    if (addr != 5'd0) begin
      if (addr == e_a3 && e_rdy)      sel = FWD_E;
      else if (addr == m_a3 && m_rdy) sel = FWD_M;
      else if (addr == w_a3)          sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: shadow E/M/W pipeline,
// stall generation and forwarding selects. Optional MDU busy stall under HAZARD_MDU_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  if (MULT_CYC > 15 || DIV_CYC > 15) begin : g_cyc_range
    $error("MULT_CYC/DIV_CYC must fit the 4-bit busy counter");
  end

  logic [4:0] E_A1, E_A2, E_A3;
  logic [2:0] E_Tnew;
  logic [4:0] M_A2, M_A3;
  logic [2:0] M_Tnew;
  logic [4:0] W_A3;
  logic       stall;
  logic       md_stall;

  function automatic logic operand_hazard(input logic [4:0] a, input logic [2:0] tuse,
                                          input logic [4:0] e_a3, input logic [2:0] e_tnew,
                                          input logic [4:0] m_a3, input logic [2:0] m_tnew);
    if (tuse == TUSE_NONE || a == 5'd0) return 1'b0;
    return (a == e_a3 && e_tnew > tuse) || (a == m_a3 && m_tnew > tuse);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      E_A1   <= '0;
      E_A2   <= '0;
      E_A3   <= '0;
      E_Tnew <= '0;
      M_A2   <= '0;
      M_A3   <= '0;
      M_Tnew <= '0;
      W_A3   <= '0;
    end else begin
      if (stall) begin
        E_A1   <= '0;
        E_A2   <= '0;
        E_A3   <= '0;
        E_Tnew <= '0;
      end else begin
        E_A1   <= hz.D_A1;
        E_A2   <= hz.D_A2;
        E_A3   <= hz.D_A3;
        E_Tnew <= hz.D_Tnew;
      end
      M_A2   <= E_A2;
      M_A3   <= E_A3;
      M_Tnew <= tnew_dec(E_Tnew);
      W_A3   <= M_A3;
    end
  end

`ifdef HAZARD_MDU_EN
  logic [1:0] E_md_start;
  logic [3:0] busy_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      E_md_start <= MD_NONE;
      busy_cnt   <= '0;
    end else begin
      E_md_start <= stall ? MD_NONE : hz.D_md_start;
      // A start in E always (re)loads, even if a previous op is still busy.
      if (E_md_start == MD_MULT)      busy_cnt <= 4'(MULT_CYC);
      else if (E_md_start == MD_DIV)  busy_cnt <= 4'(DIV_CYC);
      else if (busy_cnt != 4'd0)      busy_cnt <= busy_cnt - 4'd1;
    end
  end

  assign md_stall = hz.D_md_use && (E_md_start != MD_NONE || busy_cnt != 4'd0);
`else
  assign md_stall = 1'b0;
`endif

  always_comb begin
    stall = md_stall
          | operand_hazard(hz.D_A1, hz.D_rsTuse, E_A3, E_Tnew, M_A3, M_Tnew)
          | operand_hazard(hz.D_A2, hz.D_rtTuse, E_A3, E_Tnew, M_A3, M_Tnew);
  end

  assign hz.stall = stall;

  fwd_sel u_d_rs (
    .addr(hz.D_A1), .e_a3(E_A3), .e_rdy(E_Tnew == 3'd0),
    .m_a3(M_A3), .m_rdy(M_Tnew == 3'd0), .w_a3(W_A3), .sel(hz.D_rs_fwd)
  );

  fwd_sel u_d_rt (
    .addr(hz.D_A2), .e_a3(E_A3), .e_rdy(E_Tnew == 3'd0),
    .m_a3(M_A3), .m_rdy(M_Tnew == 3'd0), .w_a3(W_A3), .sel(hz.D_rt_fwd)
  );

  fwd_sel u_e_rs (
    .addr(E_A1), .e_a3('0), .e_rdy(1'b0),
    .m_a3(M_A3), .m_rdy(M_Tnew == 3'd0), .w_a3(W_A3), .sel(hz.E_rs_fwd)
  );

  fwd_sel u_e_rt (
    .addr(E_A2), .e_a3('0), .e_rdy(1'b0),
    .m_a3(M_A3), .m_rdy(M_Tnew == 3'd0), .w_a3(W_A3), .sel(hz.E_rt_fwd)
  );

  fwd_sel u_m_rt (
    .addr(M_A2), .e_a3('0), .e_rdy(1'b0),
    .m_a3('0), .m_rdy(1'b0), .w_a3(W_A3), .sel(hz.M_rt_fwd)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: history-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [4:0] a1, a2, a3;
    logic [2:0] tnew;
    logic [1:0] md;
  } ent_t;

  // hist[k]: instruction k stages past D (0 = E, 1 = M, 2 = W)
  ent_t hist[3];
  int   md_rem;

  function automatic int rem(input int k);
    int t = int'(hist[k].tnew);
    return (t > k) ? t - k : 0;
  endfunction

  function automatic bit op_haz(input logic [4:0] a, input logic [2:0] tu);
    if (tu == 3'd7 || a == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (hist[k].a3 == a && rem(k) > int'(tu)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    bit s;
    s = op_haz(hz.D_A1, hz.D_rsTuse) | op_haz(hz.D_A2, hz.D_rtTuse);
`ifdef HAZARD_MDU_EN
    if (hz.D_md_use && (hist[0].md != 2'd0 || md_rem > 0)) s = 1'b1;
`endif
    return s;
  endfunction

  // Youngest producer from stage 'from' onward that can supply the value; code = stage+1.
  function automatic int exp_sel(input logic [4:0] a, input int from);
    if (a == 5'd0) return 0;
    for (int k = from; k < 3; k++)
      if (hist[k].a3 == a && (k == 2 || rem(k) == 0)) return k + 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      md_rem = 0;
    end else begin
      bit   s;
      ent_t e;
      s = exp_stall();
      if (hist[0].md == 2'd1)      md_rem = 5;
      else if (hist[0].md == 2'd2) md_rem = 10;
      else if (md_rem > 0)         md_rem = md_rem - 1;
      e = '0;
      if (!s) begin
        e.a1 = hz.D_A1; e.a2 = hz.D_A2; e.a3 = hz.D_A3; e.tnew = hz.D_Tnew;
`ifdef HAZARD_MDU_EN
        e.md = hz.D_md_start;
`endif
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_stall", int'(hz.stall), int'(exp_stall()));
      check("model_D_rs_fwd", int'(hz.D_rs_fwd), exp_sel(hz.D_A1, 0));
      check("model_D_rt_fwd", int'(hz.D_rt_fwd), exp_sel(hz.D_A2, 0));
      check("model_E_rs_fwd", int'(hz.E_rs_fwd), exp_sel(hist[0].a1, 1));
      check("model_E_rt_fwd", int'(hz.E_rt_fwd), exp_sel(hist[0].a2, 1));
      check("model_M_rt_fwd", int'(hz.M_rt_fwd), exp_sel(hist[1].a2, 2));
    end
  end

  task automatic set_d(input int a1, input int t1, input int a2, input int t2,
                       input int a3, input int tn);
    hz.D_A1 = 5'(a1); hz.D_rsTuse = 3'(t1);
    hz.D_A2 = 5'(a2); hz.D_rtTuse = 3'(t2);
    hz.D_A3 = 5'(a3); hz.D_Tnew = 3'(tn);
`ifdef HAZARD_MDU_EN
    hz.D_md_start = MD_NONE; hz.D_md_use = 1'b0;
`endif
  endtask

  task automatic nop();
    set_d(0, 7, 0, 7, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_stall", int'(hz.stall), 0);
    check("rst_D_rs_fwd", int'(hz.D_rs_fwd), 0);
    check("rst_D_rt_fwd", int'(hz.D_rt_fwd), 0);
    check("rst_E_rs_fwd", int'(hz.E_rs_fwd), 0);
    check("rst_E_rt_fwd", int'(hz.E_rt_fwd), 0);
    check("rst_M_rt_fwd", int'(hz.M_rt_fwd), 0);
    chk_en = 1'b1;

    // lw $1 then addu $2,$1,$3
    set_d(0, 7, 0, 7, 1, 2); tick();
    set_d(1, 1, 3, 1, 2, 1); #1;
    check("lw_use_stall", int'(hz.stall), 1);
    tick();
    check("lw_use_release", int'(hz.stall), 0);
    check("lw_use_D_rs_none", int'(hz.D_rs_fwd), 0);
    tick(); nop(); #1;
    check("lw_use_E_rs_W", int'(hz.E_rs_fwd), 3);
    check("lw_use_E_rt_none", int'(hz.E_rt_fwd), 0);
    tick();

    // lui $4 then beq $4,$0
    set_d(0, 7, 0, 7, 4, 0); tick();
    set_d(4, 0, 0, 0, 0, 0); #1;
    check("lui_beq_stall", int'(hz.stall), 0);
    check("lui_beq_D_rs_E", int'(hz.D_rs_fwd), 1);
    check("lui_beq_D_rt_none", int'(hz.D_rt_fwd), 0);
    tick(); nop(); tick();

    // addu $5 then beq $5
    set_d(1, 1, 3, 1, 5, 1); tick();
    set_d(5, 0, 0, 0, 0, 0); #1;
    check("alu_beq_stall", int'(hz.stall), 1);
    tick();
    check("alu_beq_release", int'(hz.stall), 0);
    check("alu_beq_D_rs_M", int'(hz.D_rs_fwd), 2);
    tick(); nop(); tick();

    // ori $0 then addu reading $0
    set_d(0, 7, 0, 7, 0, 1); tick();
    set_d(0, 1, 0, 1, 3, 1); #1;
    check("r0_stall", int'(hz.stall), 0);
    check("r0_D_rs", int'(hz.D_rs_fwd), 0);
    check("r0_D_rt", int'(hz.D_rt_fwd), 0);
    tick(); nop(); #1;
    check("r0_E_rs", int'(hz.E_rs_fwd), 0);
    check("r0_E_rt", int'(hz.E_rt_fwd), 0);
    tick();

    // addu $6 then sw $6 directly behind it
    set_d(0, 7, 0, 7, 6, 1); tick();
    set_d(0, 7, 6, 2, 0, 0); #1;
    check("sw_stall", int'(hz.stall), 0);
    tick(); nop(); #1;
    check("sw_E_rt_M", int'(hz.E_rt_fwd), 2);
    tick();
    check("sw_M_rt_W", int'(hz.M_rt_fwd), 3);
    tick();

    // reset in the middle of a load-use stall
    set_d(0, 7, 0, 7, 1, 2); tick();
    set_d(1, 1, 0, 7, 2, 1); #1;
    check("rst_mid_stall_pre", int'(hz.stall), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("rst_mid_stall_post", int'(hz.stall), 0);
    tick(); nop(); tick();

    // pseudo-random instruction stream over a small register set
    for (int i = 0; i < 80; i++) begin
      set_d($urandom_range(0, 3), ($urandom_range(0, 3) == 3) ? 7 : $urandom_range(0, 2),
            $urandom_range(0, 3), ($urandom_range(0, 3) == 3) ? 7 : $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom_range(0, 2));
      tick();
    end
    nop(); repeat (3) tick();

`ifdef HAZARD_MDU_EN
    begin
      int n;
      set_d(1, 1, 2, 1, 0, 0); hz.D_md_start = MD_DIV; tick();
      set_d(0, 7, 0, 7, 8, 1); hz.D_md_use = 1'b1; #1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
        if (!hz.stall) break;
        n++;
        tick();
      end
      check("div_mfhi_stall_len", n, 11);
      nop(); repeat (2) tick();

      set_d(1, 1, 2, 1, 0, 0); hz.D_md_start = MD_DIV; tick();
      set_d(0, 7, 0, 7, 8, 1); hz.D_md_use = 1'b1; #1;
      repeat (3) tick();
      check("div_stall_cycle4", int'(hz.stall), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0; #1;
      check("div_rst_release", int'(hz.stall), 0);
      nop(); repeat (2) tick();
    end
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
